// File: rtl/regfile.sv
// rtl/regfile.sv - GPR file with HI/LO, two bypassed read ports and a raw debug port
module regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    // read port 1
    input  logic              fetch_r1_en_i,
    input  logic [4:0]        fetch_r1_addr_i,
    output logic [DATA_W-1:0] fetch_r1_data_o,
    // read port 2
    input  logic              fetch_r2_en_i,
    input  logic [4:0]        fetch_r2_addr_i,
    output logic [DATA_W-1:0] fetch_r2_data_o,
    // GPR write-back
    input  logic              wb_wreg_en_i,
    input  logic [4:0]        wb_wreg_addr_i,
    input  logic [DATA_W-1:0] wb_wreg_data_i,
    // HI/LO write-back
    input  logic              wb_hilo_en_i,
    input  logic [DATA_W-1:0] wb_hi_i,
    input  logic [DATA_W-1:0] wb_lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    // debug read, raw storage
    input  logic [4:0]        dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] gpr_q [NREG];
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              gpr_we;

    // Address 0 is hardwired to zero, so a write there is simply dropped.
    assign gpr_we = wb_wreg_en_i && (wb_wreg_addr_i != 5'd0) && (int'(wb_wreg_addr_i) < NREG);

    // Stored value of a GPR; out-of-range and register 0 read as zero.
    function automatic logic [DATA_W-1:0] stored(input logic [4:0] addr);
        if (addr == 5'd0 || int'(addr) >= NREG)
            return '0;
        return gpr_q[addr];
    endfunction

    // Bypassed read: reset, disable and r0 force zero; a same-cycle write wins over storage.
    function automatic logic [DATA_W-1:0] read_port(input logic en, input logic [4:0] addr);
        if (rst || !en || addr == 5'd0)
            return '0;
        if (wb_wreg_en_i && wb_wreg_addr_i == addr)
            return wb_wreg_data_i;
        return stored(addr);
    endfunction

    // Combinational read ports, zero-cycle latency.
    always_comb begin
        fetch_r1_data_o = read_port(fetch_r1_en_i, fetch_r1_addr_i);
        fetch_r2_data_o = read_port(fetch_r2_en_i, fetch_r2_addr_i);
        dbg_data_o      = stored(dbg_addr_i);
    end

    // HI/LO next state and write-through view.
    always_comb begin
        hi_d = wb_hilo_en_i ? wb_hi_i : hi_q;
        lo_d = wb_hilo_en_i ? wb_lo_i : lo_q;
        hi_o = rst ? '0 : hi_d;
        lo_o = rst ? '0 : lo_d;
    end

    // GPR storage: reset clears everything and overrides any concurrent write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                gpr_q[i] <= '0;
        end else if (gpr_we) begin
            gpr_q[wb_wreg_addr_i] <= wb_wreg_data_i;
        end
    end

    // HI/LO storage, written together.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - directed self-checking bench for regfile
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        r1_en, r2_en;
    logic [4:0]  r1_addr, r2_addr;
    logic [31:0] r1_data, r2_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        hilo_en;
    logic [31:0] wb_hi, wb_lo, hi, lo;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile #(.DATA_W(32), .NREG(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_r1_en_i   (r1_en),
        .fetch_r1_addr_i (r1_addr),
        .fetch_r1_data_o (r1_data),
        .fetch_r2_en_i   (r2_en),
        .fetch_r2_addr_i (r2_addr),
        .fetch_r2_data_o (r2_data),
        .wb_wreg_en_i    (wb_en),
        .wb_wreg_addr_i  (wb_addr),
        .wb_wreg_data_i  (wb_data),
        .wb_hilo_en_i    (hilo_en),
        .wb_hi_i         (wb_hi),
        .wb_lo_i         (wb_lo),
        .hi_o            (hi),
        .lo_o            (lo),
        .dbg_addr_i      (dbg_addr),
        .dbg_data_o      (dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; r1_en = 0; r2_en = 0; r1_addr = 0; r2_addr = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; hilo_en = 0; wb_hi = 0; wb_lo = 0; dbg_addr = 0;
        step();
        r1_en = 1; r1_addr = 5; #1;
        chk("reset_r1", r1_data, 32'h0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_dbg", dbg_data, 32'h0);

        // write then read
        rst = 0; wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; #1;
        chk("wr5_bypass_r1", r1_data, 32'hDEADBEEF);
        step();
        wb_en = 0; #1;
        chk("rd5_r1", r1_data, 32'hDEADBEEF);
        dbg_addr = 5; #1;
        chk("rd5_dbg", dbg_data, 32'hDEADBEEF);
        r1_en = 0; #1;
        chk("rd5_r1_disabled", r1_data, 32'h0);

        // write-through on port 2, debug sees old value until the edge
        wb_en = 1; wb_addr = 7; wb_data = 32'h12345678;
        r2_en = 1; r2_addr = 7; dbg_addr = 7; #1;
        chk("wt7_r2", r2_data, 32'h12345678);
        chk("wt7_dbg_old", dbg_data, 32'h0);
        step();
        wb_en = 0; #1;
        chk("wt7_dbg_new", dbg_data, 32'h12345678);
        r1_en = 1; r1_addr = 5; #1;
        chk("indep_r1", r1_data, 32'hDEADBEEF);
        chk("indep_r2", r2_data, 32'h12345678);

        // register zero
        wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
        r1_addr = 0; r2_addr = 0; dbg_addr = 0; #1;
        chk("r0_wcyc_r1", r1_data, 32'h0);
        chk("r0_wcyc_r2", r2_data, 32'h0);
        step();
        wb_en = 0; #1;
        chk("r0_after_r1", r1_data, 32'h0);
        chk("r0_after_r2", r2_data, 32'h0);
        chk("r0_dbg", dbg_data, 32'h0);

        // dual read of the same register, then simultaneous write
        wb_en = 1; wb_addr = 3; wb_data = 32'hA5A5A5A5;
        step();
        wb_en = 0; r1_addr = 3; r2_addr = 3; #1;
        chk("dual3_r1", r1_data, 32'hA5A5A5A5);
        chk("dual3_r2", r2_data, 32'hA5A5A5A5);
        wb_en = 1; wb_data = 32'h1; #1;
        chk("dual3_wt_r1", r1_data, 32'h1);
        chk("dual3_wt_r2", r2_data, 32'h1);
        step();
        wb_en = 0; #1;
        chk("dual3_stored", r1_data, 32'h1);

        // HI/LO
        hilo_en = 1; wb_hi = 32'h11; wb_lo = 32'h22; #1;
        chk("hilo_wt_hi", hi, 32'h11);
        chk("hilo_wt_lo", lo, 32'h22);
        step();
        hilo_en = 0; wb_hi = 32'h99; wb_lo = 32'h88; #1;
        chk("hilo_held_hi", hi, 32'h11);
        chk("hilo_held_lo", lo, 32'h22);

        // reset mid-run with a concurrent write
        wb_en = 1; wb_addr = 9; wb_data = 32'h55;
        step();
        wb_en = 1; wb_addr = 9; wb_data = 32'h77; rst = 1;
        r1_addr = 9; dbg_addr = 9; #1;
        chk("rst_r1_zero", r1_data, 32'h0);
        chk("rst_hi_zero", hi, 32'h0);
        chk("rst_dbg_stored", dbg_data, 32'h55);
        step();
        rst = 0; wb_en = 0; #1;
        chk("post_rst_r1", r1_data, 32'h0);
        chk("post_rst_dbg9", dbg_data, 32'h0);
        chk("post_rst_hi", hi, 32'h0);
        chk("post_rst_lo", lo, 32'h0);
        dbg_addr = 5; #1;
        chk("post_rst_dbg5", dbg_data, 32'h0);

        // first write after reset lands on the next edge
        wb_en = 1; wb_addr = 9; wb_data = 32'h99; dbg_addr = 9;
        step();
        wb_en = 0; #1;
        chk("first_wr_dbg", dbg_data, 32'h99);
        chk("first_wr_r1", r1_data, 32'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
